cpu_mc_control: RTL and testbench
=================================

# cpu_mc_control

Multi-cycle control unit for the 16-bit CPU, replacing the single-cycle combinational decoder. A state machine sequences each instruction through fetch, decode, execute, memory and write-back steps. It holds memory strobes until the memory acknowledges, and it detects halt, illegal opcodes and memory timeouts. It also keeps a retired-instruction counter. The block sits between the datapath's instruction register (opcode field) and all datapath/memory enables.

## Interface
- `CNT_W`, 16: width of retired-instruction counter.
- `MEM_TIMEOUT`, 0: maximum cycles to wait for `MemReady`; 0 disables the timeout.
- `TO_W`, 8: width of the timeout counter; `MEM_TIMEOUT` < 2^TO_W.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Opcode`, in, 4: `IR[15:12]` from the datapath; sampled in DECODE only.
- `MemReady`, in, 1: memory acknowledge for the current read or write.
- `IRWrite`, `PCWrite`, `PCWriteCond`, out, 1 each: instruction-register load, unconditional PC load, and branch-conditional PC load.
- `PCSrc`, out, 2: 00 = ALU result (PC+1), 01 = branch target, 10 = jump target.
- `IorD`, out, 1: 0 = PC address, 1 = ALU address.
- `MemRead`, `MemWrite`, `RegWrite`, `RegDst`, `MemToReg`, `ALUSrc`, `Shift`, out, 1 each.
- `ALUOp`, out, 2: 00 = add, 01 = sub, 10 = function field.
- `Halted`, `Illegal`, `BusErr`, out, 1 each: sticky status flags.
- `Retire`, out, 1: one-cycle pulse per completed instruction.
- `InstrCount`, out, `CNT_W`: retired-instruction count; saturates at all-ones.

## Operation
- Opcode map:
  - 0 = R-type ALU, 1 = ADDI, 2 = LW, 3 = SW, 4 = BEQ, 5 = SHIFT, 6 = JMP, 15 = HALT.
  - 7–14 are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. The opcode is latched into an internal register in DECODE.
- Outputs are a function of the current state, the latched opcode and `MemReady`. Unlisted outputs are 0.
- IDLE:
  - All outputs are 0.
  - Always goes to FETCH next cycle.
- FETCH:
  - `MemRead`=1, `IorD`=0, `ALUSrc`=0, `ALUOp`=00, `PCSrc`=00.
  - While `MemReady`=0, the FSM stays in FETCH.
  - In the cycle `MemReady`=1: `IRWrite`=1 and `PCWrite`=1, then go to DECODE.
- DECODE: no enables. Latch the opcode. Illegal opcode goes to TRAP; otherwise go to EXEC.
- EXEC, by opcode:
  - R-type: `ALUOp`=10, then WB.
  - ADDI: `ALUSrc`=1, `ALUOp`=00, then WB.
  - SHIFT: `Shift`=1, `ALUSrc`=1, then WB.
  - LW and SW: `ALUSrc`=1, `ALUOp`=00, then MEM.
  - BEQ: `ALUOp`=01, `PCWriteCond`=1, `PCSrc`=01, then retire and go to FETCH.
  - JMP: `PCWrite`=1, `PCSrc`=10, then retire and go to FETCH.
  - HALT: retire and go to HALT.
- MEM:
  - `IorD`=1. LW drives `MemRead`=1; SW drives `MemWrite`=1.
  - The strobe is held until `MemReady`=1.
  - Then LW goes to WB; SW retires and goes to FETCH.
- WB:
  - `RegWrite`=1.
  - `RegDst`=1 for R-type and SHIFT, 0 for ADDI and LW.
  - `MemToReg`=1 for LW only.
  - Retire, then go to FETCH.
- Retire:
  - `Retire`=1 in the last state of each instruction.
  - `InstrCount` increments on that edge and holds at 2^CNT_W−1.
  - HALT counts as retired. Illegal opcodes and bus errors do not.
- HALT: sets `Halted`=1 and stays until `Reset`. All enables are 0.
- TRAP: sets `Illegal`=1 (from DECODE) or `BusErr`=1 (from a timeout) and stays until `Reset`. All enables are 0.
- Timeout:
  - When `MEM_TIMEOUT`>0, a wait counter runs in FETCH and MEM. It is cleared on entry to either state and on `MemReady`.
  - If `MemReady` is still 0 after `MEM_TIMEOUT` cycles, the strobe deasserts and the FSM goes to TRAP with `BusErr`=1.
  - `MemReady` in the same cycle as the limit wins: no error.
- `MemReady` outside FETCH and MEM is ignored.

## Timing
- Reset:
  - `Reset` sampled high puts the FSM in IDLE on the next edge.
  - All outputs become 0, including `InstrCount`, `Halted`, `Illegal` and `BusErr`.
  - Reset overrides any state, including mid-MEM; strobes drop on that edge.
- Zero-wait latency (`MemReady` held 1), in cycles from FETCH entry to the next FETCH:
  - R-type, ADDI, SHIFT: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, JMP: 3.
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- `IRWrite` and `PCWrite` in FETCH are single-cycle pulses coincident with `MemReady`.

## Test plan
- Reset then R-type, `MemReady`=1: IDLE→FETCH→DECODE→EXEC→WB. `RegWrite`=1 and `RegDst`=1 in cycle 5 after reset release. `Retire` pulses once and `InstrCount`=1.
- LW with `MemReady` low for 3 MEM cycles: `MemRead` with `IorD`=1 is held for 4 cycles. WB follows with `MemToReg`=1. Total 8 cycles.
- BEQ then JMP: each takes 3 cycles. EXEC drives `PCWriteCond`=1 with `PCSrc`=01, then `PCWrite`=1 with `PCSrc`=10. `InstrCount`=2.
- Opcode 9: DECODE→TRAP, `Illegal`=1, `InstrCount` unchanged. It stays there until `Reset`, which clears `Illegal`.
- `MEM_TIMEOUT`=4, SW with `MemReady`=0: `MemWrite` holds for 4 cycles, then TRAP with `BusErr`=1. Repeat with `MemReady`=1 in the 4th cycle: no error.
- `CNT_W`=2, five ADDIs then HALT: `InstrCount` saturates at 3, and `Halted`=1. Asserting `Reset` mid-FETCH forces all outputs to 0 on the next edge.

Source files
------------

// File: rtl/cpu_mc_control.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences fetch/decode/execute/memory/write-back,
// holds memory strobes until acknowledge, traps on illegal opcodes and memory timeouts.
module cpu_mc_control #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Opcode,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic             Shift,
    output logic [1:0]       ALUOp,
    output logic             Halted,
    output logic             Illegal,
    output logic             BusErr,
    output logic             Retire,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_SHIFT = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t            state_reg, state_next;
    logic [3:0]        opcode_reg;
    logic [TO_W-1:0]   wait_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              halted_reg, illegal_reg, bus_err_reg;
    logic              set_halt, set_illegal, set_bus_err;
    logic              wait_expired;
    logic              opcode_legal;

    // Expiry fires only in the limit cycle with no acknowledge; a late MemReady still wins.
    assign wait_expired = TIMEOUT_EN && (wait_reg == WAIT_LAST) && !MemReady;
    assign opcode_legal = (Opcode <= OP_JMP) || (Opcode == OP_HALT);

    always_comb begin
        state_next  = state_reg;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        ALUSrc      = 1'b0;
        Shift       = 1'b0;
        ALUOp       = 2'b00;
        Retire      = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;

        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    state_next = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_EXEC: begin
                case (opcode_reg)
                    OP_RTYPE: begin
                        ALUOp      = 2'b10;
                        state_next = S_WB;
                    end
                    OP_ADDI: begin
                        ALUSrc     = 1'b1;
                        state_next = S_WB;
                    end
                    OP_SHIFT: begin
                        Shift      = 1'b1;
                        ALUSrc     = 1'b1;
                        state_next = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc     = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_BEQ: begin
                        ALUOp       = 2'b01;
                        PCWriteCond = 1'b1;
                        PCSrc       = 2'b01;
                        Retire      = 1'b1;
                        state_next  = S_FETCH;
                    end
                    OP_JMP: begin
                        PCWrite    = 1'b1;
                        PCSrc      = 2'b10;
                        Retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        // Only HALT reaches here; illegal opcodes never leave DECODE.
                        Retire     = 1'b1;
                        set_halt   = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (opcode_reg != OP_SW);
                MemWrite = (opcode_reg == OP_SW);
                if (MemReady) begin
                    if (opcode_reg == OP_SW) begin
                        Retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                RegDst     = (opcode_reg == OP_RTYPE) || (opcode_reg == OP_SHIFT);
                MemToReg   = (opcode_reg == OP_LW);
                Retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= S_IDLE;
            opcode_reg  <= 4'd0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_reg <= Opcode;
            end
            if (set_halt) begin
                halted_reg <= 1'b1;
            end
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    // Wait counter restarts on every state change and on each acknowledge.
    always_ff @(posedge Clock) begin
        if (Reset || (state_next != state_reg) || MemReady) begin
            wait_reg <= '0;
        end else if (TIMEOUT_EN && ((state_reg == S_FETCH) || (state_reg == S_MEM))) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (Retire && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign Halted     = halted_reg;
    assign Illegal    = illegal_reg;
    assign BusErr     = bus_err_reg;
    assign InstrCount = count_reg;

endmodule

// File: tb/tb_cpu_mc_control.sv
// Directed bench for cpu_mc_control: one default instance plus one with a 4-cycle
// memory timeout and a 2-bit retire counter, both driven by the same stimulus.
module tb_cpu_mc_control;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Opcode;
    logic       MemReady;

    logic        ir0, pcw0, pcc0, iord0, mr0, mw0, rw0, rd0, m2r0, as0, sh0, hlt0, ill0, be0, ret0;
    logic [1:0]  pcs0, aop0;
    logic [15:0] cnt0;
    logic        ir1, pcw1, pcc1, iord1, mr1, mw1, rw1, rd1, m2r1, as1, sh1, hlt1, ill1, be1, ret1;
    logic [1:0]  pcs1, aop1;
    logic [1:0]  cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    cpu_mc_control dut0 (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .IRWrite(ir0), .PCWrite(pcw0), .PCWriteCond(pcc0), .PCSrc(pcs0), .IorD(iord0),
        .MemRead(mr0), .MemWrite(mw0), .RegWrite(rw0), .RegDst(rd0), .MemToReg(m2r0),
        .ALUSrc(as0), .Shift(sh0), .ALUOp(aop0), .Halted(hlt0), .Illegal(ill0),
        .BusErr(be0), .Retire(ret0), .InstrCount(cnt0)
    );

    cpu_mc_control #(.CNT_W(2), .MEM_TIMEOUT(4), .TO_W(8)) dut1 (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .IRWrite(ir1), .PCWrite(pcw1), .PCWriteCond(pcc1), .PCSrc(pcs1), .IorD(iord1),
        .MemRead(mr1), .MemWrite(mw1), .RegWrite(rw1), .RegDst(rd1), .MemToReg(m2r1),
        .ALUSrc(as1), .Shift(sh1), .ALUOp(aop1), .Halted(hlt1), .Illegal(ill1),
        .BusErr(be1), .Retire(ret1), .InstrCount(cnt1)
    );

    // Control word: IRWrite PCWrite PCWriteCond PCSrc[1:0] IorD MemRead MemWrite
    //               RegWrite RegDst MemToReg ALUSrc Shift ALUOp[1:0] Retire
    logic [15:0] ctl0, ctl1;
    assign ctl0 = {ir0, pcw0, pcc0, pcs0, iord0, mr0, mw0, rw0, rd0, m2r0, as0, sh0, aop0, ret0};
    assign ctl1 = {ir1, pcw1, pcc1, pcs1, iord1, mr1, mw1, rw1, rd1, m2r1, as1, sh1, aop1, ret1};

    localparam logic [15:0] C_NONE     = 16'h0000;
    localparam logic [15:0] C_FETCH_W  = 16'h0200;
    localparam logic [15:0] C_FETCH_R  = 16'hC200;
    localparam logic [15:0] C_EX_R     = 16'h0004;
    localparam logic [15:0] C_EX_IMM   = 16'h0010;
    localparam logic [15:0] C_EX_BEQ   = 16'h2803;
    localparam logic [15:0] C_EX_JMP   = 16'h5001;
    localparam logic [15:0] C_EX_HALT  = 16'h0001;
    localparam logic [15:0] C_MEM_LW   = 16'h0600;
    localparam logic [15:0] C_MEM_SW   = 16'h0500;
    localparam logic [15:0] C_MEM_SWR  = 16'h0501;
    localparam logic [15:0] C_WB_R     = 16'h00C1;
    localparam logic [15:0] C_WB_ADDI  = 16'h0081;
    localparam logic [15:0] C_WB_LW    = 16'h00A1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold reset over two edges, release it; returns inside the IDLE cycle.
    task automatic do_reset();
        Reset = 1'b1;
        Opcode = 4'hE;
        MemReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
    endtask

    // Advance one edge, then apply this cycle's inputs and let outputs settle.
    task automatic step(input logic [3:0] opc, input logic rdy);
        @(posedge Clock);
        #1;
        Opcode = opc;
        MemReady = rdy;
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Opcode = 4'hE;
        MemReady = 1'b0;

        // R-type, zero wait
        do_reset();
        check("rst_ctl", ctl0, C_NONE);
        check("rst_cnt", cnt0, 0);
        check("rst_flags", {hlt0, ill0, be0}, 0);
        step(4'hE, 1'b1); check("r_fetch", ctl0, C_FETCH_R);
        step(4'h0, 1'b1); check("r_decode", ctl0, C_NONE);
        step(4'hE, 1'b1); check("r_exec", ctl0, C_EX_R);
        step(4'hE, 1'b1); check("r_wb", ctl0, C_WB_R);
        step(4'hE, 1'b0); check("r_next_fetch", ctl0, C_FETCH_W);
        check("r_cnt", cnt0, 1);
        $display("[TB] R-type retired, count %0d", cnt0);

        // LW with three wait cycles in MEM
        do_reset();
        step(4'hE, 1'b1); check("lw_fetch", ctl0, C_FETCH_R);
        step(4'h2, 1'b1); check("lw_decode", ctl0, C_NONE);
        step(4'hE, 1'b1); check("lw_exec", ctl0, C_EX_IMM);
        for (int i = 0; i < 3; i++) begin
            step(4'hE, 1'b0); check("lw_mem_wait", ctl0, C_MEM_LW);
        end
        step(4'hE, 1'b1); check("lw_mem_ack", ctl0, C_MEM_LW);
        step(4'hE, 1'b1); check("lw_wb", ctl0, C_WB_LW);
        step(4'hE, 1'b1); check("lw_next_fetch", ctl0, C_FETCH_R);
        check("lw_cnt", cnt0, 1);
        $display("[TB] LW with 3 wait cycles retired");

        // BEQ then JMP
        do_reset();
        step(4'hE, 1'b1); check("beq_fetch", ctl0, C_FETCH_R);
        step(4'h4, 1'b1); check("beq_decode", ctl0, C_NONE);
        step(4'hE, 1'b1); check("beq_exec", ctl0, C_EX_BEQ);
        step(4'hE, 1'b1); check("jmp_fetch", ctl0, C_FETCH_R);
        step(4'h6, 1'b1); check("jmp_decode", ctl0, C_NONE);
        step(4'hE, 1'b1); check("jmp_exec", ctl0, C_EX_JMP);
        step(4'hE, 1'b0); check("bj_next_fetch", ctl0, C_FETCH_W);
        check("bj_cnt", cnt0, 2);
        $display("[TB] BEQ and JMP retired, count %0d", cnt0);

        // Illegal opcode 9
        do_reset();
        step(4'hE, 1'b1);
        step(4'h9, 1'b1); check("ill_decode", ctl0, C_NONE);
        step(4'h0, 1'b1); check("ill_trap_ctl", ctl0, C_NONE);
        check("ill_flag", ill0, 1);
        check("ill_cnt", cnt0, 0);
        repeat (3) step(4'h0, 1'b1);
        check("ill_stay", {ill0, ctl0}, {1'b1, C_NONE});
        do_reset();
        check("ill_cleared", ill0, 0);
        $display("[TB] illegal opcode trapped and cleared");

        // SW timeout on the MEM_TIMEOUT=4 instance
        do_reset();
        step(4'hE, 1'b1);
        step(4'h3, 1'b1);
        step(4'hE, 1'b1); check("sw_exec", ctl1, C_EX_IMM);
        for (int i = 0; i < 4; i++) begin
            step(4'hE, 1'b0); check("sw_mem_wait", ctl1, C_MEM_SW);
        end
        step(4'hE, 1'b0); check("sw_to_ctl", ctl1, C_NONE);
        check("sw_to_buserr", be1, 1);
        check("sw_to_cnt", cnt1, 0);
        check("sw_notimeout_dflt", {be0, ctl0}, {1'b0, C_MEM_SW});
        $display("[TB] SW timeout trapped with BusErr");

        // SW acknowledged in the limit cycle
        do_reset();
        step(4'hE, 1'b1);
        step(4'h3, 1'b1);
        step(4'hE, 1'b1);
        for (int i = 0; i < 3; i++) step(4'hE, 1'b0);
        step(4'hE, 1'b1); check("sw_late_ack", ctl1, C_MEM_SWR);
        step(4'hE, 1'b1); check("sw_late_fetch", ctl1, C_FETCH_R);
        check("sw_late_buserr", be1, 0);
        check("sw_late_cnt", cnt1, 1);
        $display("[TB] SW acknowledged at limit, no error");

        // Five ADDIs then HALT: 2-bit counter saturates
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'hE, 1'b1); check("addi_fetch", ctl1, C_FETCH_R);
            check("addi_cnt_sat", cnt1, (i > 3) ? 3 : i);
            check("addi_cnt_full", cnt0, i);
            step(4'h1, 1'b1);
            step(4'hE, 1'b1); check("addi_exec", ctl1, C_EX_IMM);
            step(4'hE, 1'b1); check("addi_wb", ctl1, C_WB_ADDI);
        end
        step(4'hE, 1'b1); check("halt_fetch", ctl1, C_FETCH_R);
        step(4'hF, 1'b1);
        step(4'hE, 1'b1); check("halt_exec", ctl1, C_EX_HALT);
        step(4'hE, 1'b1); check("halt_ctl", ctl1, C_NONE);
        check("halt_flag", hlt1, 1);
        check("halt_cnt_sat", cnt1, 3);
        check("halt_cnt_full", cnt0, 6);
        step(4'hE, 1'b1); check("halt_stay", {hlt1, ctl1}, {1'b1, C_NONE});
        $display("[TB] ADDI x5 + HALT, saturated count %0d", cnt1);

        // Reset asserted mid-FETCH
        do_reset();
        step(4'hE, 1'b1);
        step(4'h1, 1'b1);
        step(4'hE, 1'b1);
        step(4'hE, 1'b1);
        step(4'hE, 1'b0); check("mrst_fetch", ctl1, C_FETCH_W);
        check("mrst_cnt_pre", cnt1, 1);
        Reset = 1'b1;
        step(4'hE, 1'b1);
        check("mrst_ctl", ctl1, C_NONE);
        check("mrst_cnt", cnt1, 0);
        check("mrst_flags", {hlt1, ill1, be1}, 0);
        Reset = 1'b0;
        $display("[TB] reset mid-FETCH cleared outputs");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
